// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO read/write gray counters.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;
  localparam int PTR_MAX     = 32;

  typedef logic [FIFO_ADDR_W:0] ptr_t;

  // Functions work on a wide zero-extended vector so any pointer width up to PTR_MAX can use them.
  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_n.sv
// Multi-flop synchronizer for a gray-coded pointer crossing clock domains.
module ptr_sync_n #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/write_gray_counter.sv
// Write-side binary/gray pointer, full/almost-full flags and write gating for the dual-clock FIFO.
// Optional sticky overflow flag is built only when WGRAY_OVERFLOW_EN is defined.
module write_gray_counter
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = FIFO_ADDR_W,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W:0]   rgray_async,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wgray,
  output logic              wfull,
  output logic              wafull,
  output logic              woverflow
);

  localparam int PW       = ADDR_W + 1;
  localparam int AFULL_TH = (2 ** ADDR_W) - AFULL_MARGIN;

  logic [ADDR_W:0] r_wbin;
  logic [ADDR_W:0] r_wgray;
  logic            r_wfull;
  logic            r_wafull;

  logic [ADDR_W:0] w_rq2;
  logic [ADDR_W:0] w_rbin;
  logic [ADDR_W:0] w_wbinnext;
  logic [ADDR_W:0] w_wgraynext;
  logic [ADDR_W:0] w_full_cmp;
  logic [ADDR_W:0] w_occ;
  logic            w_inc;

  ptr_sync_n #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rgray_async),
    .o_q (w_rq2)
  );

  assign w_inc       = write_enable & ~r_wfull;
  assign w_wbinnext  = r_wbin + {{ADDR_W{1'b0}}, w_inc};
  assign w_wgraynext = PW'(bin2gray(PTR_MAX'(w_wbinnext)));
  assign w_rbin      = PW'(gray2bin(PTR_MAX'(w_rq2)));
  assign w_occ       = w_wbinnext - w_rbin;
  // Full when the write pointer is exactly one lap ahead of the synced read pointer.
  assign w_full_cmp  = {~w_rq2[ADDR_W:ADDR_W-1], w_rq2[ADDR_W-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbin   <= '0;
      r_wgray  <= '0;
      r_wfull  <= 1'b0;
      r_wafull <= 1'b0;
    end else begin
      r_wbin   <= w_wbinnext;
      r_wgray  <= w_wgraynext;
      r_wfull  <= (w_wgraynext == w_full_cmp);
      r_wafull <= (w_occ >= PW'(AFULL_TH));
    end
  end

`ifdef WGRAY_OVERFLOW_EN
  logic r_woverflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_woverflow <= 1'b0;
    else if (write_enable & r_wfull) r_woverflow <= 1'b1;
  end

  assign woverflow = r_woverflow;
`else
  assign woverflow = 1'b0;
`endif

  assign wr_ack = w_inc;
  assign waddr  = r_wbin[ADDR_W-1:0];
  assign wgray  = r_wgray;
  assign wfull  = r_wfull;
  assign wafull = r_wafull;

endmodule

// File: tb/tb_write_gray_counter.sv
// Randomized and directed bench for write_gray_counter against an occupancy-based reference model.
module tb_write_gray_counter;

  logic       clk;
  logic       rst;
  logic       write_enable;
  logic [4:0] rgray_async;
  logic       wr_ack;
  logic [3:0] waddr;
  logic [4:0] wgray;
  logic       wfull;
  logic       wafull;
  logic       woverflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pointer as an integer count, sync chain as a delay line.
  int m_wbin;
  bit m_full, m_afull, m_ovf;
  int m_sync [2];
  int rptr;

  write_gray_counter #(
    .ADDR_W       (4),
    .SYNC_STAGES  (2),
    .AFULL_MARGIN (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .rgray_async  (rgray_async),
    .wr_ack       (wr_ack),
    .waddr        (waddr),
    .wgray        (wgray),
    .wfull        (wfull),
    .wafull       (wafull),
    .woverflow    (woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tg(input int v);
    int b;
    b = v & 31;
    return b ^ (b >> 1);
  endfunction

  function automatic int g2b(input int g);
    int b;
    b = 0;
    for (int i = 4; i >= 0; i--) b = b | ((((b >> (i + 1)) ^ (g >> i)) & 1) << i);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wbin = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    m_sync[0] = 0; m_sync[1] = 0;
  endtask

  // Drive one cycle from a negedge, update the model across the posedge, check after it.
  task automatic step(input logic we, input int rp);
    int inc, nb, occ;
    write_enable = we;
    rgray_async  = 5'(tg(rp));
    #1;
    chk("wr_ack", 32'(wr_ack), 32'(we & ~m_full));
    if (!rst) begin
      inc = (we && !m_full) ? 1 : 0;
      nb  = (m_wbin + inc) & 31;
      occ = (nb - g2b(m_sync[1])) & 31;
`ifdef WGRAY_OVERFLOW_EN
      if (we && m_full) m_ovf = 1;
`endif
      m_full    = (occ == 16);
      m_afull   = (occ >= 14);
      m_sync[1] = m_sync[0];
      m_sync[0] = tg(rp);
      m_wbin    = nb;
    end
    @(posedge clk);
    #1;
    chk("wgray",     32'(wgray),     32'(tg(m_wbin)));
    chk("waddr",     32'(waddr),     32'(m_wbin & 15));
    chk("wfull",     32'(wfull),     32'(m_full));
    chk("wafull",    32'(wafull),    32'(m_afull));
    chk("woverflow", 32'(woverflow), 32'(m_ovf));
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] prev;
    rst = 1'b1; write_enable = 1'b1; rgray_async = '0; rptr = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // 1: reset with write requested
    chk("rst_wgray", 32'(wgray), 32'h0);
    chk("rst_waddr", 32'(waddr), 32'h0);
    chk("rst_wfull", 32'(wfull), 32'h0);
    chk("rst_wafull", 32'(wafull), 32'h0);
    chk("rst_wovf", 32'(woverflow), 32'h0);
    rst = 1'b0;

    // 2: fill from empty
    for (int i = 0; i < 16; i++) begin
      chk("fill_waddr", 32'(waddr), 32'(i));
      step(1'b1, 0);
      if (i == 12) chk("afull_13", 32'(wafull), 32'h0);
      if (i == 13) chk("afull_14", 32'(wafull), 32'h1);
      if (i == 14) chk("full_15", 32'(wfull), 32'h0);
    end
    chk("fill_wgray", 32'(wgray), 32'b11000);
    chk("fill_wfull", 32'(wfull), 32'h1);

    // 3: writes while full
    for (int i = 0; i < 3; i++) step(1'b1, 0);
    chk("ovf_wgray", 32'(wgray), 32'b11000);
`ifdef WGRAY_OVERFLOW_EN
    chk("ovf_flag", 32'(woverflow), 32'h1);
`else
    chk("ovf_flag", 32'(woverflow), 32'h0);
`endif

    // 4: read pointer advances by one, full drops three edges later
    rptr = 1;
    step(1'b0, rptr); chk("rel_e1", 32'(wfull), 32'h1);
    step(1'b0, rptr); chk("rel_e2", 32'(wfull), 32'h1);
    step(1'b0, rptr); chk("rel_e3", 32'(wfull), 32'h0);
    chk("rel_afull", 32'(wafull), 32'h1);

    // 5: wrap with read pointer trailing by three
    for (int i = 0; i < 3; i++) begin
      rptr = (m_wbin - 3) & 31;
      step(1'b0, rptr);
    end
    for (int i = 0; i < 100; i++) begin
      rptr = (m_wbin - 3) & 31;
      prev = wgray;
      step(1'b1, rptr);
      chk("wrap_onebit", 32'($countones(wgray ^ prev)), 32'h1);
      chk("wrap_nofull", 32'({wfull, wafull}), 32'h0);
    end

    // Random traffic with a read pointer that never passes the write pointer
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 3) != 0 && ((m_wbin - rptr) & 31) != 0) rptr = (rptr + 1) & 31;
      step(1'($urandom % 4 != 0), rptr);
    end

    // 6: fill, overflow, then async reset mid-cycle
    for (int i = 0; i < 20; i++) step(1'b1, rptr);
    chk("pre_rst_full", 32'(wfull), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wgray", 32'(wgray), 32'h0);
    chk("arst_waddr", 32'(waddr), 32'h0);
    chk("arst_flags", 32'({wfull, wafull, woverflow}), 32'h0);
    model_reset();
    @(negedge clk);
    step(1'b1, rptr);
    rst = 1'b0;
    rptr = 0;
    step(1'b1, 0);
    step(1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
